// File: rtl/imem_loader.sv
// Instruction-memory loader: big-endian byte stream -> one IMEM write per 32-bit word.
// Define IMEM_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte per frame.
module imem_loader #(
   parameter int ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              restart,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [31:0]       wr_data,
   output logic              cpu_hold,
   output logic              done,
   output logic              error
);

   localparam int unsigned DEPTH = 2**ADDR_W;

   // S_FLUSH spans the cycle in which the final word is being written, so the
   // core is only released once that word has landed.
   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD,
`ifdef IMEM_LOADER_CHECKSUM_EN
      S_CHECK,
`endif
      S_FLUSH,
      S_DONE,
      S_ERROR
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              r_in_ready;
   logic              r_done;
   logic              r_error;
   logic              r_cpu_hold;
   logic              w_ready_nxt;
   logic              w_done_nxt;
   logic              w_error_nxt;
   logic              w_hold_nxt;

   logic [1:0]        r_byte_cnt;
   logic [ADDR_W:0]   r_index;
   logic [ADDR_W:0]   r_count;
   logic [23:0]       r_word;
   logic              r_wr_en;
   logic [ADDR_W-1:0] r_wr_addr;
   logic [31:0]       r_wr_data;
`ifdef IMEM_LOADER_CHECKSUM_EN
   logic [7:0]        r_xor;
`endif

   logic              w_accept;
   logic              w_word_end;
   logic              w_last_word;
   logic              w_count_bad;
   logic [ADDR_W:0]   w_index_inc;

   assign w_accept    = in_valid && r_in_ready;
   assign w_word_end  = w_accept && (r_byte_cnt == 2'd3);
   assign w_index_inc = r_index + 1'b1;
   assign w_last_word = w_word_end && (w_index_inc == r_count);
   assign w_count_bad = (in_data == 8'd0) || (32'(in_data) > DEPTH);

   always_comb begin
      // NOTE: every variable gets a default first so no path can infer a latch.
      w_state_nxt = r_state;
      w_ready_nxt = 1'b0;
      w_done_nxt  = 1'b0;
      w_error_nxt = 1'b0;
      w_hold_nxt  = 1'b1;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_nxt = w_count_bad ? S_ERROR : S_LOAD;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_LOAD:  if (w_last_word) w_state_nxt = S_CHECK;
         S_CHECK: if (w_accept) w_state_nxt = (in_data == r_xor) ? S_FLUSH : S_ERROR;
`else
         S_LOAD:  if (w_last_word) w_state_nxt = S_FLUSH;
`endif
         S_FLUSH: w_state_nxt = S_DONE;
         S_DONE:  if (restart) w_state_nxt = S_IDLE;
         S_ERROR: if (restart) w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase

      // Status outputs are decoded from the next state so they can be registered.
      case (w_state_nxt)
         S_IDLE:  w_ready_nxt = 1'b1;
         S_LOAD:  w_ready_nxt = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
         S_CHECK: w_ready_nxt = 1'b1;
`endif
         S_DONE: begin
            w_done_nxt = 1'b1;
            w_hold_nxt = 1'b0;
         end
         S_ERROR: w_error_nxt = 1'b1;
         default: w_ready_nxt = 1'b0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_in_ready <= 1'b1;
         r_done     <= 1'b0;
         r_error    <= 1'b0;
         r_cpu_hold <= 1'b1;
      end else begin
         r_state    <= w_state_nxt;
         r_in_ready <= w_ready_nxt;
         r_done     <= w_done_nxt;
         r_error    <= w_error_nxt;
         r_cpu_hold <= w_hold_nxt;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_byte_cnt <= '0;
         r_index    <= '0;
         r_count    <= '0;
         r_word     <= '0;
         r_wr_en    <= 1'b0;
         r_wr_addr  <= '0;
         r_wr_data  <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
         r_xor      <= '0;
`endif
      end else begin
         r_wr_en <= 1'b0;
         if (r_state == S_IDLE) begin
            r_byte_cnt <= '0;
            r_index    <= '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= '0;
`endif
            if (w_accept) r_count <= (ADDR_W+1)'(in_data);
         end else if ((r_state == S_LOAD) && w_accept) begin
            // The 2-bit byte counter wraps 3 -> 0, which clears it at each word end.
            r_word     <= {r_word[15:0], in_data};
            r_byte_cnt <= r_byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CHECKSUM_EN
            r_xor      <= r_xor ^ in_data;
`endif
            if (w_word_end) begin
               r_wr_en   <= 1'b1;
               r_wr_addr <= r_index[ADDR_W-1:0];
               r_wr_data <= {r_word, in_data};
               r_index   <= w_index_inc;
            end
         end
      end
   end

   assign in_ready = r_in_ready;
   assign done     = r_done;
   assign error    = r_error;
   assign cpu_hold = r_cpu_hold;
   assign wr_en    = r_wr_en;
   assign wr_addr  = r_wr_addr;
   assign wr_data  = r_wr_data;

endmodule

// File: doc/imem_loader.md
# imem_loader

Instruction-memory loader for the five-stage pipeline: the write side of the fetch stage's instruction memory, which the fetch stage only reads. It accepts a byte stream from a host over a valid/ready handshake, assembles big-endian 32-bit words, and issues one write per word into the instruction memory. The core is held in reset until a complete program has landed.

## Interface
- ADDR_W, 5, instruction-memory word-address width; DEPTH = 2**ADDR_W words (32 by default)
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset (0 = reset)
- in_data  in  8  stream byte
- in_valid  in  1  in_data is valid
- in_ready  out  1  loader accepts a byte this cycle
- restart  in  1  single-cycle request to reload; honoured only in DONE or ERROR
- wr_en  out  1  instruction-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word index being written (the fetch stage reads with pc[31:2])
- wr_data  out  32  instruction word
- cpu_hold  out  1  drives the pipeline's reset; 1 while no valid program is loaded
- done  out  1  program loaded
- error  out  1  load aborted

## Operation
- Frame: one count byte N, then 4·N data bytes, each word MSB first. With checksum enabled, one checksum byte follows (see Configuration).
- A byte transfers on any rising edge where in_valid && in_ready.
- States:
  - IDLE: in_ready=1. The count byte is accepted.
    - N==0 or N>DEPTH → ERROR.
    - Otherwise latch N, clear the word index and byte counter → LOAD.
  - LOAD: in_ready=1.
    - Shift each byte into the word register: word = {word[23:0], in_data}.
    - On byte 4 of a word: register wr_en=1, wr_addr=index, wr_data=word for the next cycle, increment index, clear the byte counter.
    - After word N is accepted → DONE, or → CHECK if the checksum is enabled.
  - CHECK (checksum build only): in_ready=1. One byte accepted; match → DONE, mismatch → ERROR.
  - DONE: in_ready=0, done=1, cpu_hold=0. restart → IDLE.
  - ERROR: in_ready=0, error=1, cpu_hold=1. restart → IDLE.
- cpu_hold is 1 in IDLE, LOAD, CHECK and ERROR, and 0 only in DONE.
- Words at addresses ≥ N are not touched. Memory contents from an aborted or partial load are left as written.
- restart in IDLE, LOAD or CHECK is ignored.
- A mid-load reset returns the block to the reset state. Partially written words remain in memory.

## Timing
- Reset values: state=IDLE, in_ready=1 after reset release, wr_en=0, wr_addr=0, wr_data=0, done=0, error=0, cpu_hold=1.
- All outputs are registered.
- Write latency: wr_en is high in the cycle immediately after the edge that accepts byte 4 of a word, and for exactly one cycle. The memory captures the word on the following edge.
- Throughput: one byte per cycle with no backpressure inside a frame, so the peak write rate is one word every 4 cycles.
- Final word (checksum disabled): the accept edge E sets wr_en. The next edge, E+1, writes the memory and sets done=1 and cpu_hold=0. The core leaves reset only after the last word is in memory.
- restart: the edge that samples restart=1 in DONE/ERROR sets state=IDLE, done=0, error=0, cpu_hold=1, in_ready=1. A byte is never accepted on that same edge, because in_ready was 0.
- Index width is ADDR_W+1 bits so that N=DEPTH is counted without wrap. wr_addr takes the low ADDR_W bits.

## Configuration
- IMEM_LOADER_CHECKSUM_EN defined:
  - The frame carries a trailing byte equal to the XOR of all 4·N data bytes (the count byte is excluded).
  - The XOR accumulator is cleared in IDLE.
  - done is set on the edge after a matching checksum byte is accepted. cpu_hold stays 1 through CHECK.
- Undefined:
  - There is no CHECK state.
  - DONE follows the last word's write as described under Timing.
  - The frame is N·4+1 bytes.

## Test plan
- Count 0x01, bytes 20 0A 00 05 → one wr_en pulse with wr_addr=0, wr_data=0x200A0005; done=1 and cpu_hold=0 one cycle later.
- Count 0x0A with the ten-word ADDI/NOP/SW/NOP/LW/NOP/ADD program (ADD word 0x014B6020 at addr 9), in_valid toggled randomly → exactly 10 writes at addrs 0..9 in order with matching data; cpu_hold stays 1 until after the addr-9 write.
- Count 0x00, then a separate run with count 0x21 → ERROR, error=1, in_ready=0, no wr_en; restart pulse → IDLE with error=0.
- Count 0x20 (DEPTH), 128 bytes → writes at addrs 0..31 with no wrap; done=1.
- Reset asserted after the 2nd byte of word 3 → all outputs return to reset values immediately; a fresh frame then loads correctly from addr 0.
- IMEM_LOADER_CHECKSUM_EN: count 0x01, 8C 0B 00 14, checksum 0x93 → done=1; same frame with checksum 0x00 → error=1 and cpu_hold=1.
